spi_flash_loader: RTL

//  SPI initiator that bulk-copies a serial flash region into the SRAM hierarchy.
//  - Drives the flash pins (cs/sck/si), samples so, packs bytes into words, writes sram_ctrl.
//  - Issues READ 0x03 (or FAST_READ 0x0B), then a 24-bit address, then streams data.
//  - Sits between the flash chip and sram_ctrl; replaces the CPU as the flash master at boot.

---
 rtl/spi_flash_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_flash_loader.sv
// Boot-time SPI mode-0 initiator: READ 0x03 (or FAST_READ 0x0B with FLASH_FAST_READ_EN) + 24b address, streams len words LE into SRAM.
// No backpressure: sram_we is always accepted; start is sampled only in IDLE.
module spi_flash_loader #(
    parameter int CLK_DIV = 2,
    parameter int SRAM_AW = 10,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [23:0]        flash_addr,
    input  logic [SRAM_AW-1:0] sram_base,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    output logic               flash_cs,
    output logic               flash_sck,
    output logic               flash_si,
    input  logic               flash_so,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata
);

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

    localparam int CW = $clog2(2 * CLK_DIV + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BUSY_LAST = CW'(2 * CLK_DIV);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA, LAST_FALL, CS_HOLD, DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [4:0]         bit_cnt;
    logic [31:0]        tx;
    logic [30:0]        shreg;
    logic [LEN_W-1:0]   words_left;
    logic [SRAM_AW-1:0] next_addr;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            tx         <= '0;
            shreg      <= '0;
            words_left <= '0;
            next_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            flash_cs   <= 1'b1;
            flash_sck  <= 1'b0;
            flash_si   <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            done    <= 1'b0;
            sram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            // Command MSB goes out with the CS fall; tx holds the rest of cmd+addr.
                            flash_cs   <= 1'b0;
                            flash_sck  <= 1'b0;
                            busy       <= 1'b1;
                            flash_si   <= CMD_BYTE[7];
                            tx         <= {CMD_BYTE[6:0], flash_addr, 1'b0};
                            words_left <= len - 1'b1;
                            next_addr  <= sram_base;
                            cnt        <= '0;
                            bit_cnt    <= '0;
                            state      <= CMD;
                        end
                    end
                end
                CMD, ADDR, DUMMY, DATA: begin
                    if (cnt == DIV_LAST) begin
                        cnt       <= '0;
                        flash_sck <= ~flash_sck;
                        if (flash_sck) begin
                            // Falling edge: present next bit; zeros once cmd+addr are exhausted.
                            flash_si <= tx[31];
                            tx       <= {tx[30:0], 1'b0};
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (state == CMD && bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                state   <= ADDR;
                            end else if (state == ADDR && bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
`ifdef FLASH_FAST_READ_EN
                                state   <= DUMMY;
`else
                                state   <= DATA;
`endif
                            end else if (state == DUMMY && bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                state   <= DATA;
                            end else if (state == DATA) begin
                                shreg <= {shreg[29:0], flash_so};
                                if (bit_cnt == 5'd31) begin
                                    bit_cnt    <= '0;
                                    sram_we    <= 1'b1;
                                    sram_addr  <= next_addr;
                                    sram_wdata <= byte_swap({shreg, flash_so});
                                    next_addr  <= next_addr + 1'b1;
                                    if (words_left == '0) begin
                                        state <= LAST_FALL;
                                    end else begin
                                        words_left <= words_left - 1'b1;
                                    end
                                end
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LAST_FALL: begin
                    if (cnt == DIV_LAST) begin
                        cnt       <= '0;
                        flash_sck <= 1'b0;
                        state     <= CS_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CS_HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        flash_cs <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Keeps busy up to guarantee minimum CS-high time before the next start.
                    if (cnt == BUSY_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
